// File: rtl/axi_master_arbiter_if.sv
// -----------------------------------------------------------------------------
// axi_master_arbiter_if
//
// Bundles every bus signal around the two-master / one-slave AXI4 arbiter:
// the fetch-unit port (M0, read only), the load/store-unit port (M1, read and
// write), the downstream slave port and the registered grant.
//
// Payloads are packed vectors:
//   AR/AW : {addr, id, len[7:0], size[2:0], burst[1:0]}   ADDR_W+ID_W+13 bits
//   R     : {data, resp[1:0], id, last}                   DATA_W+ID_W+3 bits
//   W     : {data, strb, last}                            DATA_W+DATA_W/8+1 bits
//   B     : {resp[1:0], id}                               ID_W+2 bits
//
// Modports:
//   master : the arbiter's view (owns slave-side valids, master-side readies,
//            the returned R/B towards the masters and the grant)
//   slave  : the surrounding system's view (masters and downstream slave)
// -----------------------------------------------------------------------------
interface axi_master_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int ID_W   = 4
);
  localparam int AX_W = ADDR_W + ID_W + 8 + 3 + 2;
  localparam int R_W  = DATA_W + 2 + ID_W + 1;
  localparam int W_W  = DATA_W + DATA_W / 8 + 1;
  localparam int B_W  = 2 + ID_W;

  logic            m0_req;
  logic            m1_req;

  logic            m0_arvalid;
  logic            m0_arready;
  logic [AX_W-1:0] m0_ar;
  logic            m0_rvalid;
  logic            m0_rready;
  logic [R_W-1:0]  m0_r;

  logic            m1_arvalid;
  logic            m1_arready;
  logic [AX_W-1:0] m1_ar;
  logic            m1_rvalid;
  logic            m1_rready;
  logic [R_W-1:0]  m1_r;
  logic            m1_awvalid;
  logic            m1_awready;
  logic [AX_W-1:0] m1_aw;
  logic            m1_wvalid;
  logic            m1_wready;
  logic [W_W-1:0]  m1_w;
  logic            m1_bvalid;
  logic            m1_bready;
  logic [B_W-1:0]  m1_b;

  logic            s_arvalid;
  logic            s_arready;
  logic [AX_W-1:0] s_ar;
  logic            s_rvalid;
  logic            s_rready;
  logic [R_W-1:0]  s_r;
  logic            s_awvalid;
  logic            s_awready;
  logic [AX_W-1:0] s_aw;
  logic            s_wvalid;
  logic            s_wready;
  logic [W_W-1:0]  s_w;
  logic            s_bvalid;
  logic            s_bready;
  logic [B_W-1:0]  s_b;

  logic [1:0]      grant;

  modport master (
    input  m0_req, m1_req,
    input  m0_arvalid, m0_ar, m0_rready,
    output m0_arready, m0_rvalid, m0_r,
    input  m1_arvalid, m1_ar, m1_rready, m1_awvalid, m1_aw, m1_wvalid, m1_w, m1_bready,
    output m1_arready, m1_rvalid, m1_r, m1_awready, m1_wready, m1_bvalid, m1_b,
    output s_arvalid, s_ar, s_rready, s_awvalid, s_aw, s_wvalid, s_w, s_bready,
    input  s_arready, s_rvalid, s_r, s_awready, s_wready, s_bvalid, s_b,
    output grant
  );

  modport slave (
    output m0_req, m1_req,
    output m0_arvalid, m0_ar, m0_rready,
    input  m0_arready, m0_rvalid, m0_r,
    output m1_arvalid, m1_ar, m1_rready, m1_awvalid, m1_aw, m1_wvalid, m1_w, m1_bready,
    input  m1_arready, m1_rvalid, m1_r, m1_awready, m1_wready, m1_bvalid, m1_b,
    input  s_arvalid, s_ar, s_rready, s_awvalid, s_aw, s_wvalid, s_w, s_bready,
    output s_arready, s_rvalid, s_r, s_awready, s_wready, s_bvalid, s_b,
    input  grant
  );
endinterface

// File: rtl/axi_master_arbiter.sv
// -----------------------------------------------------------------------------
// axi_master_arbiter
//
// Shares one downstream AXI4 port between the fetch unit (M0, read only) and
// the load/store unit (M1, read and write). One master owns the bus per
// transaction; its channels are wired combinationally to the slave while the
// other master sees all readies/valids low and zero payloads.
//
// Ports:
//   clock : rising-edge clock
//   reset : asynchronous, active-high
//   bus   : axi_master_arbiter_if.master (M0, M1 and slave channels, grant)
//
// Build option:
//   AXI_ARB_ROUND_ROBIN_EN - when defined, simultaneous requests in IDLE go to
//   the master that was not granted last (last_grant resets to M0). When
//   undefined, M1 always wins a tie.
//
// The interface must be instantiated with the same ADDR_W/DATA_W/ID_W.
// -----------------------------------------------------------------------------
module axi_master_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int ID_W   = 4
) (
  input  logic                 clock,
  input  logic                 reset,
  axi_master_arbiter_if.master bus
);
  localparam int AX_W = ADDR_W + ID_W + 8 + 3 + 2;
  localparam int R_W  = DATA_W + 2 + ID_W + 1;
  localparam int W_W  = DATA_W + DATA_W / 8 + 1;
  localparam int B_W  = 2 + ID_W;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GNT_M0 = 2'd1,
    GNT_M1 = 2'd2
  } state_t;

  state_t state_q, state_d;
  logic   addr_sent_q, rd_pend_q, wr_pend_q;
  logic   gnt_m0, gnt_m1;
  logic   ar_hs, aw_hs, rd_done, wr_done, txn_done;
  logic   req_cur, release_early, win_m1;

  // Handshakes are taken on the slave side; those valids are already gated by
  // the grant and by addr_sent, so they only fire for the owning master.
  assign ar_hs   = bus.s_arvalid & bus.s_arready;
  assign aw_hs   = bus.s_awvalid & bus.s_awready;
  // R payload LSB is rlast.
  assign rd_done = rd_pend_q & bus.s_rvalid & bus.s_rready & bus.s_r[0];
  assign wr_done = wr_pend_q & bus.s_bvalid & bus.s_bready;

  // With AR and AW both outstanding, the transaction ends only once both the
  // rlast beat and the B response have been seen (in either order).
  assign txn_done = addr_sent_q & (rd_done | wr_done)
                  & ~(rd_pend_q & ~rd_done) & ~(wr_pend_q & ~wr_done);

  assign req_cur       = gnt_m1 ? bus.m1_req : bus.m0_req;
  // A flushed fetch can withdraw its request until an address has gone out.
  assign release_early = ~addr_sent_q & ~req_cur & ~ar_hs & ~aw_hs;

`ifdef AXI_ARB_ROUND_ROBIN_EN
  // 0 = M0 granted last, 1 = M1 granted last.
  logic last_grant_q;

  assign win_m1 = bus.m1_req & (~bus.m0_req | ~last_grant_q);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      last_grant_q <= 1'b0;
    end else if (state_q == IDLE && state_d != IDLE) begin
      last_grant_q <= (state_d == GNT_M1);
    end
  end
`else
  assign win_m1 = bus.m1_req;
`endif

  // State register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: every grant returns through IDLE, so back-to-back
  // transactions always see one idle cycle.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (bus.m0_req | bus.m1_req) begin
          state_d = win_m1 ? GNT_M1 : GNT_M0;
        end
      end
      GNT_M0, GNT_M1: begin
        if (txn_done | release_early) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outstanding-transaction tracking, cleared whenever the grant is dropped.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      addr_sent_q <= 1'b0;
      rd_pend_q   <= 1'b0;
      wr_pend_q   <= 1'b0;
    end else if (state_d == IDLE) begin
      addr_sent_q <= 1'b0;
      rd_pend_q   <= 1'b0;
      wr_pend_q   <= 1'b0;
    end else begin
      if (ar_hs | aw_hs) begin
        addr_sent_q <= 1'b1;
      end
      if (ar_hs) begin
        rd_pend_q <= 1'b1;
      end else if (rd_done) begin
        rd_pend_q <= 1'b0;
      end
      if (aw_hs) begin
        wr_pend_q <= 1'b1;
      end else if (wr_done) begin
        wr_pend_q <= 1'b0;
      end
    end
  end

  // Output logic: channel routing decoded from the registered state.
  always_comb begin
    gnt_m0 = (state_q == GNT_M0);
    gnt_m1 = (state_q == GNT_M1);
    bus.grant = {gnt_m1, gnt_m0};

    bus.s_arvalid  = 1'b0;
    bus.s_ar       = {AX_W{1'b0}};
    bus.s_rready   = 1'b0;
    bus.s_awvalid  = 1'b0;
    bus.s_aw       = {AX_W{1'b0}};
    bus.s_wvalid   = 1'b0;
    bus.s_w        = {W_W{1'b0}};
    bus.s_bready   = 1'b0;

    bus.m0_arready = 1'b0;
    bus.m0_rvalid  = 1'b0;
    bus.m0_r       = {R_W{1'b0}};

    bus.m1_arready = 1'b0;
    bus.m1_rvalid  = 1'b0;
    bus.m1_r       = {R_W{1'b0}};
    bus.m1_awready = 1'b0;
    bus.m1_wready  = 1'b0;
    bus.m1_bvalid  = 1'b0;
    bus.m1_b       = {B_W{1'b0}};

    if (gnt_m0) begin
      // Only one address per grant: further AR is held off once one went out.
      bus.s_arvalid  = bus.m0_arvalid & ~addr_sent_q;
      bus.s_ar       = bus.m0_ar;
      bus.m0_arready = bus.s_arready & ~addr_sent_q;
      bus.m0_rvalid  = bus.s_rvalid;
      bus.m0_r       = bus.s_r;
      bus.s_rready   = bus.m0_rready;
    end

    if (gnt_m1) begin
      bus.s_arvalid  = bus.m1_arvalid & ~addr_sent_q;
      bus.s_ar       = bus.m1_ar;
      bus.m1_arready = bus.s_arready & ~addr_sent_q;
      bus.m1_rvalid  = bus.s_rvalid;
      bus.m1_r       = bus.s_r;
      bus.s_rready   = bus.m1_rready;
      bus.s_awvalid  = bus.m1_awvalid & ~addr_sent_q;
      bus.s_aw       = bus.m1_aw;
      bus.m1_awready = bus.s_awready & ~addr_sent_q;
      // W is not gated by addr_sent: the data beat may lead or trail AW.
      bus.s_wvalid   = bus.m1_wvalid;
      bus.s_w        = bus.m1_w;
      bus.m1_wready  = bus.s_wready;
      bus.m1_bvalid  = bus.s_bvalid;
      bus.m1_b       = bus.s_b;
      bus.s_bready   = bus.m1_bready;
    end
  end
endmodule

// File: tb/tb_axi_master_arbiter.sv
// -----------------------------------------------------------------------------
// tb_axi_master_arbiter
//
// Directed bench for axi_master_arbiter: single fetch read, LSU write with
// W ahead of AW, simultaneous requests, early release, 4-beat burst with an
// error on the last beat, and asynchronous reset mid-transaction. Expected
// grant order under simultaneous requests follows AXI_ARB_ROUND_ROBIN_EN.
// -----------------------------------------------------------------------------
module tb_axi_master_arbiter;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int ID_W   = 4;

  logic clock = 1'b0;
  logic reset;
  int   n_vec  = 0;
  int   n_miss = 0;

  axi_master_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .ID_W(ID_W)) bus ();

  axi_master_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .ID_W(ID_W)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  logic [4:0]  m1_hs;
  logic [11:0] all_hs;
  assign m1_hs  = {bus.m1_arready, bus.m1_rvalid, bus.m1_awready, bus.m1_wready, bus.m1_bvalid};
  assign all_hs = {bus.s_arvalid, bus.s_rready, bus.s_awvalid, bus.s_wvalid, bus.s_bready,
                   bus.m0_arready, bus.m0_rvalid, m1_hs};

  task automatic check_vec(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clock);
    @(negedge clock);
  endtask

  function automatic logic [48:0] ax(input logic [31:0] a, input logic [3:0] id, input logic [7:0] len);
    return {a, id, len, 3'd2, 2'd1};
  endfunction

  function automatic logic [38:0] rbeat(input logic [31:0] d, input logic [1:0] resp,
                                        input logic [3:0] id, input logic last);
    return {d, resp, id, last};
  endfunction

  task automatic clear_inputs;
    bus.m0_req = 0; bus.m1_req = 0;
    bus.m0_arvalid = 0; bus.m0_ar = '0; bus.m0_rready = 0;
    bus.m1_arvalid = 0; bus.m1_ar = '0; bus.m1_rready = 0;
    bus.m1_awvalid = 0; bus.m1_aw = '0; bus.m1_wvalid = 0; bus.m1_w = '0; bus.m1_bready = 0;
    bus.s_arready = 0; bus.s_rvalid = 0; bus.s_r = '0; bus.s_awready = 0;
    bus.s_wready = 0; bus.s_bvalid = 0; bus.s_b = '0;
  endtask

  // Single-beat read by the currently granted master; ends back in IDLE.
  task automatic rd_one(input bit use_m1, input logic [31:0] data);
    logic [48:0] a;
    logic [38:0] r;
    a = ax(32'h8000_0200, 4'h2, 8'd0);
    r = rbeat(data, 2'b00, 4'h2, 1'b1);
    if (use_m1) begin
      bus.m1_arvalid = 1; bus.m1_ar = a;
    end else begin
      bus.m0_arvalid = 1; bus.m0_ar = a;
    end
    bus.s_arready = 1;
    #1;
    check_vec("t3_ar_fwd", 64'(bus.s_ar), 64'(a));
    tick;
    bus.m0_arvalid = 0; bus.m1_arvalid = 0; bus.s_arready = 0;
    bus.s_rvalid = 1; bus.s_r = r;
    bus.m0_rready = !use_m1; bus.m1_rready = use_m1;
    #1;
    check_vec("t3_r_route", 64'(use_m1 ? bus.m1_r : bus.m0_r), 64'(r));
    tick;
    bus.s_rvalid = 0; bus.m0_rready = 0; bus.m1_rready = 0;
  endtask

  logic [48:0] ar_v;
  logic [38:0] r_v;
  logic [36:0] w_v;
  bit          first_m1;

  initial begin
    clear_inputs();
    reset = 1;
    @(negedge clock);
    #1;
    // Reset state
    check_vec("rst_grant", 64'(bus.grant), 64'(2'b00));
    check_vec("rst_hs", 64'(all_hs), 64'(12'h000));
    reset = 0;
    @(negedge clock);

    // Test 1: fetch-only single read
    ar_v = ax(32'h8000_0000, 4'h0, 8'd0);
    bus.m0_req = 1; bus.m0_arvalid = 1; bus.m0_ar = ar_v;
    #1;
    check_vec("t1_pre_grant", 64'(bus.grant), 64'(2'b00));
    tick;
    check_vec("t1_grant", 64'(bus.grant), 64'(2'b01));
    check_vec("t1_ar_fwd", 64'(bus.s_ar), 64'(ar_v));
    bus.s_arready = 1;
    #1;
    check_vec("t1_arready", 64'(bus.m0_arready), 64'(1'b1));
    tick;
    // Address already sent: a second AR must be held off.
    for (int i = 0; i < 2; i++) begin
      #1;
      check_vec("t1_ar_block", 64'({bus.s_arvalid, bus.m0_arready}), 64'(2'b00));
      check_vec("t1_hold", 64'(bus.grant), 64'(2'b01));
      check_vec("t1_m1_quiet", 64'(m1_hs), 64'(5'h00));
      tick;
    end
    bus.m0_arvalid = 0; bus.s_arready = 0;
    r_v = rbeat(32'h0000_0413, 2'b00, 4'h0, 1'b1);
    bus.s_rvalid = 1; bus.s_r = r_v; bus.m0_rready = 1;
    #1;
    check_vec("t1_r_data", 64'(bus.m0_r), 64'(r_v));
    check_vec("t1_r_hs", 64'({bus.m0_rvalid, bus.s_rready}), 64'(2'b11));
    check_vec("t1_m1_quiet_r", 64'(m1_hs), 64'(5'h00));
    tick;
    bus.s_rvalid = 0; bus.m0_rready = 0; bus.m0_req = 0;
    #1;
    check_vec("t1_release", 64'(bus.grant), 64'(2'b00));
    @(negedge clock);

    // Test 2: LSU write, W ahead of AW
    w_v = {32'hDEAD_BEEF, 4'b1111, 1'b1};
    bus.m1_req = 1; bus.m1_wvalid = 1; bus.m1_w = w_v;
    tick;
    check_vec("t2_grant", 64'(bus.grant), 64'(2'b10));
    check_vec("t2_w_fwd", 64'({bus.s_wvalid, bus.s_w}), 64'({1'b1, w_v}));
    bus.s_wready = 1;
    #1;
    check_vec("t2_wready", 64'(bus.m1_wready), 64'(1'b1));
    tick;
    bus.m1_wvalid = 0; bus.s_wready = 0;
    tick;
    ar_v = ax(32'h8000_0100, 4'h1, 8'd0);
    bus.m1_awvalid = 1; bus.m1_aw = ar_v; bus.s_awready = 1;
    #1;
    check_vec("t2_aw_fwd", 64'({bus.s_awvalid, bus.m1_awready, bus.s_aw}), 64'({2'b11, ar_v}));
    tick;
    bus.m1_awvalid = 0; bus.s_awready = 0;
    tick;
    check_vec("t2_wait_b", 64'(bus.grant), 64'(2'b10));
    bus.s_bvalid = 1; bus.s_b = {2'b00, 4'h1}; bus.m1_bready = 1;
    #1;
    check_vec("t2_b_route", 64'({bus.m1_bvalid, bus.s_bready, bus.m1_b}), 64'({2'b11, 6'h01}));
    tick;
    bus.s_bvalid = 0; bus.m1_bready = 0; bus.m1_req = 0;
    #1;
    check_vec("t2_release", 64'(bus.grant), 64'(2'b00));
    @(negedge clock);

    // Test 3: simultaneous requests (previous grant was M1)
`ifdef AXI_ARB_ROUND_ROBIN_EN
    first_m1 = 1'b0;
`else
    first_m1 = 1'b1;
`endif
    bus.m0_req = 1; bus.m1_req = 1;
    tick;
    check_vec("t3_first", 64'(bus.grant), 64'(first_m1 ? 2'b10 : 2'b01));
    rd_one(first_m1, 32'h1111_2222);
    if (first_m1) bus.m1_req = 0; else bus.m0_req = 0;
    #1;
    check_vec("t3_idle_gap", 64'(bus.grant), 64'(2'b00));
    tick;
    check_vec("t3_second", 64'(bus.grant), 64'(first_m1 ? 2'b01 : 2'b10));

    // Test 4: granted master withdraws before any address, other is waiting
    if (first_m1) begin
      bus.m0_req = 0; bus.m1_req = 1;
    end else begin
      bus.m1_req = 0; bus.m0_req = 1;
    end
    tick;
    check_vec("t4_early_rel", 64'(bus.grant), 64'(2'b00));
    tick;
    check_vec("t4_regrant", 64'(bus.grant), 64'(first_m1 ? 2'b10 : 2'b01));
    bus.m0_req = 0; bus.m1_req = 0;
    tick;
    check_vec("t4_drop", 64'(bus.grant), 64'(2'b00));

    // Test 5: 4-beat M1 burst, SLVERR on the last beat
    ar_v = ax(32'h8000_0300, 4'h3, 8'd3);
    bus.m1_req = 1; bus.m1_arvalid = 1; bus.m1_ar = ar_v; bus.s_arready = 1;
    tick;
    check_vec("t5_grant", 64'(bus.grant), 64'(2'b10));
    tick;
    bus.m1_arvalid = 0; bus.s_arready = 0; bus.m1_rready = 1;
    for (int i = 0; i < 4; i++) begin
      r_v = rbeat(32'(32'hA0 + i), (i == 3) ? 2'b10 : 2'b00, 4'h3, (i == 3));
      bus.s_rvalid = 1; bus.s_r = r_v;
      #1;
      check_vec("t5_beat", 64'(bus.m1_r), 64'(r_v));
      tick;
      check_vec("t5_hold", 64'(bus.grant), 64'((i == 3) ? 2'b00 : 2'b10));
    end
    bus.s_rvalid = 0; bus.m1_rready = 0; bus.m1_req = 0;
    @(negedge clock);

    // Test 6: asynchronous reset one cycle after an M1 AR handshake
    ar_v = ax(32'h8000_0400, 4'h4, 8'd1);
    bus.m1_req = 1; bus.m1_arvalid = 1; bus.m1_ar = ar_v; bus.s_arready = 1;
    tick;
    check_vec("t6_grant", 64'(bus.grant), 64'(2'b10));
    tick;
    bus.m1_arvalid = 0; bus.s_arready = 0;
    tick;
    bus.s_rvalid = 1; bus.s_r = rbeat(32'h55, 2'b00, 4'h4, 1'b0); bus.m1_rready = 1;
    #1;
    check_vec("t6_pre_rst", 64'(bus.m1_rvalid), 64'(1'b1));
    reset = 1;
    #1;
    check_vec("t6_rst_grant", 64'(bus.grant), 64'(2'b00));
    check_vec("t6_rst_hs", 64'(all_hs), 64'(12'h000));
    @(negedge clock);
    reset = 0;
    clear_inputs();
    ar_v = ax(32'h8000_0500, 4'h5, 8'd0);
    bus.m0_req = 1; bus.m0_arvalid = 1; bus.m0_ar = ar_v;
    tick;
    check_vec("t6_post_grant", 64'(bus.grant), 64'(2'b01));
    check_vec("t6_post_ar", 64'({bus.s_arvalid, bus.s_ar}), 64'({1'b1, ar_v}));
    clear_inputs();
    tick;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule
